// File: rtl/ttl_pkg.sv
// ---------------------------------------------------------------------------
// ttl_pkg
//   Shared definitions for the ttl_* block family.
//   - ttl_mode_e : two-bit operating mode, packed as {Enable_bar, Mode_bar}
//   - DEMUX_LATCH_WIDTH : default number of outputs of ttl_demux_latch
// ---------------------------------------------------------------------------
package ttl_pkg;

    typedef enum logic [1:0] {
        MODE_DEMUX  = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_MEMORY = 2'b11
    } ttl_mode_e;

    localparam int DEMUX_LATCH_WIDTH = 8;

endpackage : ttl_pkg

// File: rtl/ttl_demux_latch_ptr.sv
// ---------------------------------------------------------------------------
// ttl_demux_latch_ptr
//   Wrapping slot pointer for the auto-addressing mode of ttl_demux_latch.
//   Priority: clear > load > incr. Counts 0 .. WIDTH_OUT-1 and emits a
//   registered one-cycle wrap pulse on the increment that returns it to 0.
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     clear      synchronous clear of pointer and wrap
//     load       load load_value into the pointer
//     load_value value to load
//     incr       advance the pointer by one (wrapping)
//     ptr        current pointer value
//     wrap       high for the cycle after a wrapping increment
// ---------------------------------------------------------------------------
module ttl_demux_latch_ptr #(
    parameter int WIDTH_OUT    = 8,
    parameter int WIDTH_SELECT = $clog2(WIDTH_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [WIDTH_SELECT-1:0] load_value,
    input  logic                    incr,
    output logic [WIDTH_SELECT-1:0] ptr,
    output logic                    wrap
);

    localparam logic [WIDTH_SELECT-1:0] PTR_LAST = WIDTH_SELECT'(WIDTH_OUT - 1);
    localparam logic [WIDTH_SELECT-1:0] PTR_ONE  = WIDTH_SELECT'(1);

    logic [WIDTH_SELECT-1:0] ptr_reg;
    logic [WIDTH_SELECT-1:0] ptr_next;
    logic                    wrap_reg;
    logic                    wrap_next;

    always_comb begin
        ptr_next  = ptr_reg;
        wrap_next = 1'b0;
        if (clear) begin
            ptr_next = '0;
        end else if (load) begin
            ptr_next = load_value;
        end else if (incr) begin
            if (ptr_reg == PTR_LAST) begin
                ptr_next  = '0;
                wrap_next = 1'b1;
            end else begin
                // A pointer loaded beyond the last slot (non-power-of-two
                // widths) simply counts on and rolls over at 2**WIDTH_SELECT.
                ptr_next = ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            ptr_reg  <= ptr_next;
            wrap_reg <= wrap_next;
        end
    end

    assign ptr  = ptr_reg;
    assign wrap = wrap_reg;

endmodule : ttl_demux_latch_ptr

// File: rtl/ttl_demux_latch.sv
// ---------------------------------------------------------------------------
// ttl_demux_latch
//   Clocked addressable demultiplexing latch. One data bit D is steered into
//   one of WIDTH_OUT registered outputs, addressed by Select or (when the
//   auto feature is built in) by an internal wrapping pointer.
//
//   Mode {Enable_bar, Mode_bar}:
//     01 LATCH  : Q[A] <= D, other bits hold
//     11 MEMORY : Q holds
//     00 DEMUX  : Q <= 0 except Q[A] <= D
//     10 CLEAR  : Q <= 0, Ptr <= 0
//   Addresses beyond WIDTH_OUT-1 match no output bit.
//
//   Build option: define ttl_DEMUX_LATCH_AUTO_EN to enable the Auto input,
//   the pointer and Wrap. Without it, Auto is ignored and Ptr/Wrap are 0.
//
//   Ports:
//     Clk        rising-edge clock
//     Clear      asynchronous, active-high reset (Q, Ptr, Wrap -> 0)
//     Enable_bar active-low write enable
//     Mode_bar   high: latch/memory, low: demux/clear
//     Auto       high: address from Ptr, low: address from Select
//     Select     explicit address
//     D          data bit
//     Q          latched outputs
//     Ptr        current pointer value
//     Wrap       one-cycle pulse after the pointer wraps
// ---------------------------------------------------------------------------
module ttl_demux_latch
    import ttl_pkg::*;
#(
    parameter int WIDTH_OUT    = DEMUX_LATCH_WIDTH,
    parameter int WIDTH_SELECT = $clog2(WIDTH_OUT),
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                    Clk,
    input  logic                    Clear,
    input  logic                    Enable_bar,
    input  logic                    Mode_bar,
    input  logic                    Auto,
    input  logic [WIDTH_SELECT-1:0] Select,
    input  logic                    D,
    output logic [WIDTH_OUT-1:0]    Q,
    output logic [WIDTH_SELECT-1:0] Ptr,
    output logic                    Wrap
);

    // Rise/fall delays only describe the timing of the modelled TTL part;
    // this implementation is zero-delay, so they are only range-checked.
    if (WIDTH_OUT < 2) begin : g_bad_width
        $error("ttl_demux_latch: WIDTH_OUT must be at least 2");
    end
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("ttl_demux_latch: delays must be non-negative");
    end

    ttl_mode_e               mode;
    logic [WIDTH_SELECT-1:0] addr;
    logic [WIDTH_OUT-1:0]    q_reg;
    logic [WIDTH_OUT-1:0]    q_next;

    assign mode = ttl_mode_e'({Enable_bar, Mode_bar});

`ifdef ttl_DEMUX_LATCH_AUTO_EN
    logic [WIDTH_SELECT-1:0] ptr_value;
    logic                    wrap_value;

    // Auto=0 tracks Select every cycle; Auto=1 advances after each write
    // (LATCH or DEMUX) and holds in MEMORY. CLEAR wins over both.
    ttl_demux_latch_ptr #(
        .WIDTH_OUT    (WIDTH_OUT),
        .WIDTH_SELECT (WIDTH_SELECT)
    ) u_ptr (
        .clk        (Clk),
        .rst        (Clear),
        .clear      (mode == MODE_CLEAR),
        .load       (!Auto),
        .load_value (Select),
        .incr       (Auto && !Enable_bar),
        .ptr        (ptr_value),
        .wrap       (wrap_value)
    );

    // The write in a cycle uses the pointer value held during that cycle.
    assign addr = Auto ? ptr_value : Select;
    assign Ptr  = ptr_value;
    assign Wrap = wrap_value;
`else
    logic unused_auto;

    assign unused_auto = Auto;
    assign addr        = Select;
    assign Ptr         = '0;
    assign Wrap        = 1'b0;
`endif

    // Per-bit next-state: each output bit decodes its own address match, so
    // an out-of-range address naturally writes nothing.
    for (genvar gi = 0; gi < WIDTH_OUT; gi++) begin : g_bit
        localparam logic [WIDTH_SELECT-1:0] BIT_ADDR = WIDTH_SELECT'(gi);

        logic hit;
        logic bit_next;

        assign hit = (addr == BIT_ADDR);

        always_comb begin
            bit_next = q_reg[gi];
            case (mode)
                MODE_LATCH:  if (hit) bit_next = D;
                MODE_MEMORY: bit_next = q_reg[gi];
                MODE_DEMUX:  bit_next = hit & D;
                MODE_CLEAR:  bit_next = 1'b0;
                default:     bit_next = q_reg[gi];
            endcase
        end

        assign q_next[gi] = bit_next;
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q = q_reg;

endmodule : ttl_demux_latch

// File: tb/tb_ttl_demux_latch.sv
// ---------------------------------------------------------------------------
// tb_ttl_demux_latch
//   Directed test of ttl_demux_latch. An 8-output instance and a 6-output
//   instance share all inputs; expected values are hand-computed below.
//   Auto-mode steps are built only with ttl_DEMUX_LATCH_AUTO_EN defined;
//   the Auto-ignored steps only without it.
// ---------------------------------------------------------------------------
module tb_ttl_demux_latch;

`ifdef ttl_DEMUX_LATCH_AUTO_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic       clk;
    logic       clear;
    logic       enable_bar;
    logic       mode_bar;
    logic       auto_sel;
    logic [2:0] sel;
    logic       d;
    logic [7:0] q8;
    logic [2:0] ptr8;
    logic       wrap8;
    logic [5:0] q6;
    logic [2:0] ptr6;
    logic       wrap6;

    int n_asserts = 0;
    int n_fail    = 0;

    ttl_demux_latch #(.WIDTH_OUT(8)) dut (
        .Clk        (clk),
        .Clear      (clear),
        .Enable_bar (enable_bar),
        .Mode_bar   (mode_bar),
        .Auto       (auto_sel),
        .Select     (sel),
        .D          (d),
        .Q          (q8),
        .Ptr        (ptr8),
        .Wrap       (wrap8)
    );

    ttl_demux_latch #(.WIDTH_OUT(6)) dut6 (
        .Clk        (clk),
        .Clear      (clear),
        .Enable_bar (enable_bar),
        .Mode_bar   (mode_bar),
        .Auto       (auto_sel),
        .Select     (sel),
        .D          (d),
        .Q          (q6),
        .Ptr        (ptr6),
        .Wrap       (wrap6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
            $display("check %-14s observed %02h expected %02h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic eb, input logic mb, input logic au,
                         input logic [2:0] s, input logic dd);
        enable_bar = eb;
        mode_bar   = mb;
        auto_sel   = au;
        sel        = s;
        d          = dd;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        check("rst_q",   q8, 8'h00);
        check("rst_ptr", {5'd0, ptr8}, 8'h00);
        check("rst_wrap", {7'd0, wrap8}, 8'h00);
        check("rst_q6",  {2'b00, q6}, 8'h00);
        @(posedge clk);
        #2;
        clear = 1'b0;

        // LATCH writes
        drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b1); tick();
        check("latch_s3", q8, 8'h08);
        drive(1'b0, 1'b1, 1'b0, 3'd6, 1'b1); tick();
        check("latch_s6", q8, 8'h48);
        check("ptr_follow", {5'd0, ptr8}, AUTO_ON ? 8'h06 : 8'h00);
        drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b0); tick();
        check("latch_s3_d0", q8, 8'h40);

        // Fill with ones; the 6-wide part ignores addresses 6 and 7
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'(i), 1'b1); tick();
        end
        check("fill_q8", q8, 8'hFF);
        check("fill_q6", {2'b00, q6}, 8'h3F);

        // DEMUX then MEMORY hold
        drive(1'b0, 1'b0, 1'b0, 3'd2, 1'b1); tick();
        check("demux_s2", q8, 8'h04);
        check("demux_s2_q6", {2'b00, q6}, 8'h04);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'(i * 3 + 1), i[0]); tick();
            check("memory_hold", q8, 8'h04);
        end

        // Out-of-range address on the 6-wide part
        drive(1'b0, 1'b0, 1'b0, 3'd7, 1'b1); tick();
        check("demux_s7", q8, 8'h80);
        check("demux_oor_q6", {2'b00, q6}, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1); tick();
        check("latch_oor_q6", {2'b00, q6}, 8'h00);
        check("latch_s7", q8, 8'h80);

        // CLEAR mode
        drive(1'b1, 1'b0, 1'b1, 3'd5, 1'b1); tick();
        check("clr_mode_q", q8, 8'h00);
        check("clr_mode_ptr", {5'd0, ptr8}, 8'h00);
        check("clr_mode_wrap", {7'd0, wrap8}, 8'h00);

        // Build Q=A5, Ptr=5, then assert Clear between edges
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1); tick();
        drive(1'b1, 1'b1, 1'b0, 3'd5, 1'b0); tick();
        check("pre_clr_q", q8, 8'hA5);
        check("pre_clr_ptr", {5'd0, ptr8}, AUTO_ON ? 8'h05 : 8'h00);
        #2;
        clear = 1'b1;
        #1;
        check("async_clr_q", q8, 8'h00);
        check("async_clr_ptr", {5'd0, ptr8}, 8'h00);
        check("async_clr_wrap", {7'd0, wrap8}, 8'h00);
        check("async_clr_q6", {2'b00, q6}, 8'h00);
        @(posedge clk);
        #2;
        clear = 1'b0;

`ifdef ttl_DEMUX_LATCH_AUTO_EN
        // Auto sweep from 6
        drive(1'b1, 1'b1, 1'b0, 3'd6, 1'b0); tick();
        check("auto_load", {5'd0, ptr8}, 8'h06);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 1'b1); tick();
        check("auto1_q", q8, 8'h40);
        check("auto1_ptr", {5'd0, ptr8}, 8'h07);
        check("auto1_wrap", {7'd0, wrap8}, 8'h00);
        tick();
        check("auto2_q", q8, 8'hC0);
        check("auto2_ptr", {5'd0, ptr8}, 8'h00);
        check("auto2_wrap", {7'd0, wrap8}, 8'h01);
        tick();
        check("auto3_q", q8, 8'hC1);
        check("auto3_ptr", {5'd0, ptr8}, 8'h01);
        check("auto3_wrap", {7'd0, wrap8}, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 3'd3, 1'b0); tick();
        check("auto_mem_ptr", {5'd0, ptr8}, 8'h01);
        check("auto_mem_q", q8, 8'hC1);

        // CLEAR priority over Auto, also dropping a pending Wrap
        drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b0); tick();
        check("load4_ptr", {5'd0, ptr8}, 8'h04);
        drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        tick(); tick(); tick();
        check("auto4_q", q8, 8'hF1);
        check("auto4_ptr", {5'd0, ptr8}, 8'h07);
        tick();
        check("auto_wrap2", {7'd0, wrap8}, 8'h01);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 1'b1); tick();
        check("clr_pri_q", q8, 8'h00);
        check("clr_pri_ptr", {5'd0, ptr8}, 8'h00);
        check("clr_pri_wrap", {7'd0, wrap8}, 8'h00);

        // Async Clear mid-sequence, restart from slot 0
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b1);
        tick(); tick();
        check("seq_q", q8, 8'h03);
        check("seq_ptr", {5'd0, ptr8}, 8'h02);
        #2;
        clear = 1'b1;
        #1;
        check("seq_clr_q", q8, 8'h00);
        check("seq_clr_ptr", {5'd0, ptr8}, 8'h00);
        @(posedge clk);
        #2;
        clear = 1'b0;
        tick();
        check("restart_q", q8, 8'h01);
        check("restart_ptr", {5'd0, ptr8}, 8'h01);
`else
        // Auto ignored: Select addresses, Ptr/Wrap stay 0
        drive(1'b0, 1'b1, 1'b1, 3'd2, 1'b1); tick();
        check("noauto_q6", {2'b00, q6}, 8'h04);
        check("noauto_q8", q8, 8'h04);
        check("noauto_ptr6", {5'd0, ptr6}, 8'h00);
        check("noauto_ptr8", {5'd0, ptr8}, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 3'd7, 1'b1); tick();
        check("noauto_oor_q6", {2'b00, q6}, 8'h00);
        check("noauto_s7_q8", q8, 8'h80);
        check("noauto_wrap6", {7'd0, wrap6}, 8'h00);
        check("noauto_wrap8", {7'd0, wrap8}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_ttl_demux_latch
